// File: rtl/abs_chk_pkg.sv
// Shared constants and FSM state type for the reference-memory result checker.
package abs_chk_pkg;

    localparam int unsigned ABS_CHK_N       = 1024;
    localparam int unsigned ABS_CHK_DW      = 8;
    localparam int unsigned ABS_CHK_AW      = 10;
    localparam int unsigned ABS_CHK_TIMEOUT = 4096;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } chk_state_t;

    // RUN accepts samples, DRAIN finishes the last compare; both count as busy.
    function automatic logic chk_is_busy(input chk_state_t s);
        return (s == ST_RUN) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/abs_result_checker_if.sv
// Sample stream, reference-memory port and result bundle of the checker.
interface abs_result_checker_if
    import abs_chk_pkg::*;
#(
    parameter int unsigned DW = ABS_CHK_DW,
    parameter int unsigned AW = ABS_CHK_AW
) ();

    logic          start;
    logic          val_i;
    logic [DW-1:0] abs_i;
    logic [AW-1:0] ref_addr_o;
    logic [DW-1:0] ref_data_i;
    logic          busy_o;
    logic          done_o;
    logic          pass_o;
    logic          timeout_o;
    logic [AW:0]   err_cnt_o;
    logic [AW-1:0] first_err_idx_o;
    logic [DW-1:0] first_err_exp_o;
    logic [DW-1:0] first_err_got_o;

    // Source side: sample producer, reference memory and result consumer.
    modport master (
        output start, val_i, abs_i, ref_data_i,
        input  ref_addr_o, busy_o, done_o, pass_o, timeout_o,
        input  err_cnt_o, first_err_idx_o, first_err_exp_o, first_err_got_o
    );

    // Checker side.
    modport slave (
        input  start, val_i, abs_i, ref_data_i,
        output ref_addr_o, busy_o, done_o, pass_o, timeout_o,
        output err_cnt_o, first_err_idx_o, first_err_exp_o, first_err_got_o
    );

endinterface

// File: rtl/abs_chk_timeout.sv
// Idle-cycle counter: cleared on i_clr, counts on i_en, flags the TIMEOUT-th idle cycle.
module abs_chk_timeout
    import abs_chk_pkg::*;
#(
    parameter int unsigned TIMEOUT = ABS_CHK_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    // o_tc is high during the cycle that completes TIMEOUT consecutive idle cycles.
    assign o_tc = i_en && (r_cnt == CW'(TIMEOUT - 1));

    // Idle counter; holds at the terminal value instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_tc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/abs_result_checker.sv
// Compares a stream of magnitude samples against an external synchronous-read
// reference memory and reports mismatch count, first mismatch and idle timeout.
module abs_result_checker
    import abs_chk_pkg::*;
#(
    parameter int unsigned N       = ABS_CHK_N,
    parameter int unsigned DW      = ABS_CHK_DW,
    parameter int unsigned AW      = ABS_CHK_AW,
    parameter int unsigned TIMEOUT = ABS_CHK_TIMEOUT
) (
    input logic                 clk,
    input logic                 rst,
    abs_result_checker_if.slave bus
);

    chk_state_t    r_state;
    chk_state_t    w_next;

    logic [AW-1:0] r_idx;
    logic          r_val;
    logic [DW-1:0] r_abs;
    logic [AW-1:0] r_pidx;
    logic [AW:0]   r_err;
    logic          r_timeout;
    logic [AW-1:0] r_first_idx;
    logic [DW-1:0] r_first_exp;
    logic [DW-1:0] r_first_got;

    logic          w_accept;
    logic          w_last;
    logic          w_start_frame;
    logic          w_idle_en;
    logic          w_idle_clr;
    logic          w_tc;
    logic          w_mismatch;

    assign w_accept      = (r_state == ST_RUN) && bus.val_i;
    assign w_last        = (r_idx == AW'(N - 1));
    assign w_start_frame = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_idle_en     = (r_state == ST_RUN) && !bus.val_i;
    assign w_idle_clr    = (r_state != ST_RUN) || bus.val_i;
    // ref_data_i belongs to the sample captured last cycle (address was r_idx then).
    assign w_mismatch    = r_val && (r_abs != bus.ref_data_i);

    abs_chk_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_idle_clr),
        .i_en  (w_idle_en),
        .o_tc  (w_tc)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; start only acts from IDLE or DONE.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (bus.start) w_next = ST_RUN;
            ST_RUN: begin
                if (w_accept && w_last) begin
                    w_next = ST_DRAIN;
                end else if (w_tc) begin
                    w_next = ST_DONE;
                end
            end
            ST_DRAIN: w_next = ST_DONE;
            ST_DONE:  if (bus.start) w_next = ST_RUN;
            default:  w_next = ST_IDLE;
        endcase
    end

    // One-stage sample pipeline aligned with the 1-cycle reference read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_val  <= 1'b0;
            r_abs  <= '0;
            r_pidx <= '0;
        end else begin
            r_val  <= w_accept;
            r_abs  <= bus.abs_i;
            r_pidx <= r_idx;
        end
    end

    // Sample index, mismatch accounting and timeout flag; cleared when a frame is armed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= '0;
            r_err       <= '0;
            r_timeout   <= 1'b0;
            r_first_idx <= '0;
            r_first_exp <= '0;
            r_first_got <= '0;
        end else if (w_start_frame) begin
            r_idx       <= '0;
            r_err       <= '0;
            r_timeout   <= 1'b0;
            r_first_idx <= '0;
            r_first_exp <= '0;
            r_first_got <= '0;
        end else begin
            if (w_accept && !w_last) begin
                r_idx <= r_idx + 1'b1;
            end
            if (w_tc) begin
                r_timeout <= 1'b1;
            end
            if (w_mismatch) begin
                if (r_err != '1) begin
                    r_err <= r_err + 1'b1;
                end
                // A zero count means no mismatch has been recorded yet this frame.
                if (r_err == '0) begin
                    r_first_idx <= r_pidx;
                    r_first_exp <= bus.ref_data_i;
                    r_first_got <= r_abs;
                end
            end
        end
    end

    assign bus.ref_addr_o      = r_idx;
    assign bus.busy_o          = chk_is_busy(r_state);
    assign bus.done_o          = (r_state == ST_DONE);
    assign bus.pass_o          = (r_state == ST_DONE) && (r_err == '0) && !r_timeout;
    assign bus.timeout_o       = r_timeout;
    assign bus.err_cnt_o       = r_err;
    assign bus.first_err_idx_o = r_first_idx;
    assign bus.first_err_exp_o = r_first_exp;
    assign bus.first_err_got_o = r_first_got;

endmodule

// File: doc/abs_result_checker.md
ABS_RESULT_CHECKER -- requirements
Module: abs_result_checker

Interface
REQ-001 SHALL have parameter N, default 1024, meaning samples per frame.
REQ-002 SHALL have parameter DW, default 8, meaning magnitude sample width.
REQ-003 SHALL have parameter AW, default 10, meaning reference-memory address width (2^AW >= N).
REQ-004 SHALL have parameter TIMEOUT, default 4096, meaning max idle cycles between samples in RUN.
REQ-005 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port start  in  1  one-cycle pulse that arms a new frame check.
REQ-008 SHALL have port val_i  in  1  magnitude sample valid, from the CalAbs val_o.
REQ-009 SHALL have port abs_i  in  DW  magnitude sample, from the CalAbs abs_o.
REQ-010 SHALL have port ref_addr_o  out  AW  reference-memory read address.
REQ-011 SHALL have port ref_data_i  in  DW  reference-memory data, synchronous read, 1-cycle latency.
REQ-012 SHALL have port busy_o  out  1  high in RUN and DRAIN.
REQ-013 SHALL have port done_o  out  1  high in DONE.
REQ-014 SHALL have port pass_o  out  1  valid while done_o=1: err_cnt_o==0 and timeout_o==0.
REQ-015 SHALL have port timeout_o  out  1  frame ended by idle timeout.
REQ-016 SHALL have port err_cnt_o  out  AW+1  mismatch count, saturating at 2^(AW+1)-1.
REQ-017 SHALL have port first_err_idx_o  out  AW  index of first mismatch.
REQ-018 SHALL have port first_err_exp_o / first_err_got_o  out  DW each  expected/received value at first mismatch.

Function
REQ-019 SHALL implement FSM IDLE, RUN, DRAIN, DONE; val_i ignored in IDLE and DONE.
REQ-020 SHALL go IDLE->RUN on start, clearing sample index, err_cnt_o, timeout_o, first-error record, idle counter.
REQ-021 SHALL drive ref_addr_o from registered sample index; index increments on each val_i=1 in RUN.
REQ-022 SHALL register val_i/abs_i one stage and compare delayed abs against ref_data_i on the following cycle, giving 1-cycle compare latency and supporting val_i on every cycle.
REQ-023 SHALL increment err_cnt_o per mismatch; first mismatch latches index, expected, received; later mismatches do not alter record.
REQ-024 SHALL go RUN->DRAIN when sample index N-1 is accepted; DRAIN->DONE after that last compare (exactly one cycle).
REQ-025 SHALL count idle cycles in RUN (reset on val_i=1); reaching TIMEOUT sets timeout_o and goes RUN->DONE directly (no pending compare lost: a compare in flight still completes that cycle).
REQ-026 SHALL hold DONE and all result outputs stable until start, which re-enters RUN with REQ-020 clearing.
REQ-027 SHALL ignore start in RUN and DRAIN.
REQ-028 SHALL treat rst mid-frame as abort: next cycle state IDLE, no partial result retained.
REQ-029 SHALL, on N==2^AW, stop index at N-1 (no wrap into index 0 within a frame).

Reset
REQ-030 SHALL on rst set state IDLE, ref_addr_o=0, busy_o=0, done_o=0, pass_o=0, timeout_o=0, err_cnt_o=0, first_err_idx_o=0, first_err_exp_o=0, first_err_got_o=0, pipeline valid=0.
REQ-031 SHALL give rst priority over start and val_i in the same cycle.

Structure
REQ-032 SHALL place state encoding and default N/DW/AW/TIMEOUT constants in shared package abs_chk_pkg.
REQ-033 SHALL use one sub-module, abs_chk_timeout, a loadable idle counter with terminal-count flag; reference memory stays external.

Verification
REQ-034 SHALL cover: start, 1024 back-to-back correct samples -> done_o 1025 cycles after first val_i accepted... checked as done_o=1 two cycles after last val_i, pass_o=1, err_cnt_o=0.
REQ-035 SHALL cover: sample 37 corrupted (ref 0x5A, sent 0x5B) -> err_cnt_o=1, first_err_idx_o=37, exp 0x5A, got 0x5B, pass_o=0.
REQ-036 SHALL cover: errors at 5 and 900 -> err_cnt_o=2, first_err_idx_o=5.
REQ-037 SHALL cover: val_i toggling 1,0 pattern over full frame -> same result as back-to-back, pass_o=1.
REQ-038 SHALL cover: stream stops after 500 samples -> TIMEOUT cycles later done_o=1, timeout_o=1, pass_o=0.
REQ-039 SHALL cover: rst at sample 300, then start and full clean frame -> pass_o=1, err_cnt_o=0.
